// File: rtl/div_seq.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, with
// the EX stage stalled until the HI (remainder) / LO (quotient) pair is ready.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             annul,
    output logic             stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic             q_neg, r_neg;

    logic             accept;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_new, quo_new;

    // Two's complement negate when neg is set; wraps modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v) + WIDTH'(1) : v;
    endfunction

    assign accept       = (state == IDLE) && start && !annul;
    assign result_valid = (state == DONE);
    assign stall        = start & ~result_valid & ~annul;

    // One restoring step: remainder carries an extra bit so the shift cannot overflow.
    assign rem_sh    = {rem, quo[WIDTH-1]};
    assign diff      = rem_sh - {1'b0, dvs};
    assign no_borrow = (rem_sh >= {1'b0, dvs});
    assign rem_new   = no_borrow ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_new   = {quo[WIDTH-2:0], no_borrow};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !annul) begin
                    state_nxt = (opb == '0) ? DIVZERO : BUSY;
                end
            end
            DIVZERO: state_nxt = annul ? IDLE : DONE;
            BUSY: begin
                if (annul) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!start || annul) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (accept && (opb != '0)) begin
                quo   <= cond_neg(opa, signed_div & opa[WIDTH-1]);
                dvs   <= cond_neg(opb, signed_div & opb[WIDTH-1]);
                rem   <= '0;
                cnt   <= '0;
                q_neg <= (opa[WIDTH-1] ^ opb[WIDTH-1]) & signed_div;
                r_neg <= opa[WIDTH-1] & signed_div;
            end
            if ((state == BUSY) && !annul) begin
                rem <= rem_new;
                quo <= quo_new;
                cnt <= cnt + CNT_W'(1);
                if (cnt == LAST) begin
                    lo <= cond_neg(quo_new, q_neg);
                    hi <= cond_neg(rem_new, r_neg);
                end
            end
            // Divide by zero is architecturally unpredictable; pin the result to 0.
            if ((state == DIVZERO) && !annul) begin
                hi <= '0;
                lo <= '0;
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: signed/unsigned divides, divide-by-zero,
// annulment mid-division and asynchronous reset mid-division.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        annul;
    logic        stall;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .signed_div   (signed_div),
        .opa          (opa),
        .opb          (opb),
        .annul        (annul),
        .stall        (stall),
        .result_valid (result_valid),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Raise start, scramble operands after the first edge, wait for result_valid.
    task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] elo,
                           input logic [31:0] ehi, input int ecyc);
        int   cyc;
        logic low;
        @(negedge clk);
        signed_div = s; opa = a; opb = b; start = 1'b1;
        #1;
        check({tag, "_stall_req"}, stall, 1'b1);
        cyc = 0;
        low = 1'b0;
        while (!result_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                opa = ~a; opb = b + 32'd3; signed_div = ~s;
            end
            if (!result_valid && !stall) low = 1'b1;
        end
        check({tag, "_latency"}, cyc, ecyc);
        check({tag, "_lo"}, lo, elo);
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_stall_done"}, stall, 1'b0);
        check({tag, "_stall_hold"}, low, 1'b0);
    endtask

    task automatic finish_div(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, result_valid, 1'b0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; signed_div = 1'b0;
        opa = '0; opb = '0; annul = 1'b0;
        #12;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_valid", result_valid, 1'b0);
        check("rst_stall", stall, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        run_div("divu_7_2", 1'b0, 32'd7, 32'd2, 32'h3, 32'h1, 33);
        finish_div("divu_7_2");
        run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
        finish_div("div_m7_2");
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1, 33);
        finish_div("div_7_m2");
        run_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 33);
        finish_div("div_min_m1");
        run_div("divu_min_max", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33);
        finish_div("divu_min_max");

        // A known nonzero result first, so the zeroing by divide-by-zero is visible.
        run_div("divu_100_7a", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        finish_div("divu_100_7a");
        run_div("divu_zero", 1'b0, 32'd5, 32'd0, 32'h0, 32'h0, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("divz_hold_valid", result_valid, 1'b1);
            check("divz_hold_stall", stall, 1'b0);
        end
        check("divz_hold_lo", lo, 32'h0);
        finish_div("divu_zero");
        run_div("div_zero", 1'b1, 32'hFFFFFFF0, 32'd0, 32'h0, 32'h0, 2);
        finish_div("div_zero");

        // Annul at iteration 10: prior result must survive.
        run_div("divu_9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 33);
        finish_div("divu_9_4");
        @(negedge clk);
        signed_div = 1'b0; opa = 32'd1000; opb = 32'd3; start = 1'b1;
        repeat (11) @(negedge clk);
        annul = 1'b1;
        #1;
        check("annul_stall", stall, 1'b0);
        @(negedge clk);
        check("annul_valid", result_valid, 1'b0);
        check("annul_lo", lo, 32'd2);
        check("annul_hi", hi, 32'd1);
        annul = 1'b0; start = 1'b0;
        @(negedge clk);
        check("annul_idle_valid", result_valid, 1'b0);
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        finish_div("divu_100_7");

        // Asynchronous reset at iteration 20.
        @(negedge clk);
        signed_div = 1'b0; opa = 32'h12345678; opb = 32'd3; start = 1'b1;
        repeat (21) @(negedge clk);
        #2;
        resetn = 1'b0; start = 1'b0;
        #1;
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        check("arst_valid", result_valid, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("arst_idle_valid", result_valid, 1'b0);
        run_div("divu_max_16", 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 33);
        finish_div("divu_max_16");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
